// File: rtl/wb_regfile.sv
// Register file with write-back bypass and a per-register pending scoreboard.
// Index 0 reads as zero; busy flags a read whose producer has not yet written back.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_wreg,
  input  logic [ADDR_W-1:0] wb_wd,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              re1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              issue_set,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic              flush,
  output logic              busy1,
  output logic              busy2
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [NREG-1:0]   pending_q;
  logic [NREG-1:0]   pending_d;

  logic              wb_en;
  logic              iss_en;

  assign wb_en  = wb_wreg && (wb_wd != '0);
  assign iss_en = issue_set && (issue_rd != '0);

  // Entry 0 never takes a write, so it stays at its reset value of zero.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_next
    if (gi == 0) begin : g_zero
      assign regs_d[gi] = '0;
    end else begin : g_entry
      assign regs_d[gi] = (wb_en && (wb_wd == ADDR_W'(gi))) ? wb_wdata : regs_q[gi];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (!rst) regs_q[i] <= '0;
      else      regs_q[i] <= regs_d[i];
    end
  end

  // Ordering matters: flush first, then writeback clear, then issue set (newest owner wins).
  always_comb begin
    pending_d = pending_q;
    if (flush) pending_d = '0;
    if (wb_en) pending_d[wb_wd] = 1'b0;
    if (iss_en) pending_d[issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) pending_q <= '0;
    else      pending_q <= pending_d;
  end

  logic              re_v    [2];
  logic [ADDR_W-1:0] raddr_v [2];
  logic [DATA_W-1:0] rdata_v [2];
  logic              busy_v  [2];

  assign re_v[0]    = re1;
  assign re_v[1]    = re2;
  assign raddr_v[0] = raddr1;
  assign raddr_v[1] = raddr2;

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic hit_zero;
    logic hit_wb;
    assign hit_zero    = (raddr_v[gi] == '0);
    assign hit_wb      = wb_wreg && (wb_wd == raddr_v[gi]);
    assign rdata_v[gi] = (!re_v[gi] || hit_zero) ? '0 :
                         hit_wb                  ? wb_wdata :
                                                   regs_q[raddr_v[gi]];
    assign busy_v[gi]  = re_v[gi] && !hit_zero && pending_q[raddr_v[gi]] && !hit_wb;
  end

  assign rdata1 = rdata_v[0];
  assign rdata2 = rdata_v[1];
  assign busy1  = busy_v[0];
  assign busy2  = busy_v[1];

endmodule
